// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer for the UART receiver: circular store, show-ahead read port.
// Optional character timeout is built when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned AF_LEVEL = 12,
  parameter int unsigned TO_TICKS = 640
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  input  logic              s_tick,
  input  logic              rd,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              almost_full,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic              timeout
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_W-1:0] r_ptr_q, r_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              wr_acc, rd_acc;

  assign empty       = (count_q == '0);
  assign full        = (count_q == (ADDR_W + 1)'(Depth));
  assign almost_full = (count_q >= (ADDR_W + 1)'(AF_LEVEL));
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign dout        = mem_q[r_ptr_q];

  // A pop on a full buffer frees the slot the same edge, so the write is accepted.
  assign wr_acc = wr & (~full | rd);
  assign rd_acc = rd & ~empty;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (wr_acc) begin
      w_ptr_d = w_ptr_q + ADDR_W'(1);
    end
    if (rd_acc) begin
      r_ptr_d = r_ptr_q + ADDR_W'(1);
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    // Set takes priority over a coincident clear.
    if (wr && full && !rd) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (wr_acc) begin
        mem_q[w_ptr_q] <= din;
      end
    end
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TO_TICKS + 1);
  localparam logic [ToW-1:0] ToMax = ToW'(TO_TICKS);

  logic [ToW-1:0] to_cnt_q, to_cnt_d;

  // Any traffic or an empty buffer restarts the inactivity window; count saturates.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (empty || wr_acc || rd_acc) begin
      to_cnt_d = '0;
    end else if (s_tick && (to_cnt_q != ToMax)) begin
      to_cnt_d = to_cnt_q + ToW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign timeout = (to_cnt_q == ToMax);
`else
  logic unused_s_tick;
  assign unused_s_tick = s_tick;
  assign timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo; timeout expectations follow
// UART_RX_FIFO_TIMEOUT_EN.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       s_tick = 1'b0;
  logic       rd = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] dout;
  logic       empty, full, almost_full, overflow, timeout;
  logic [4:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr          (wr),
    .din         (din),
    .s_tick      (s_tick),
    .rd          (rd),
    .dout        (dout),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .almost_full (almost_full),
    .overflow    (overflow),
    .clr_ovf     (clr_ovf),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] d);
    wr  = 1'b1;
    din = d;
    tick();
    wr  = 1'b0;
  endtask

  task automatic do_pop();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_af"}, 32'(almost_full), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_to"}, 32'(timeout), 32'd0);
    check({tag, "_dout"}, 32'(dout), 32'h00);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #10;
    check_reset_state("rst");
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Single byte round trip, then pop on empty is ignored.
    do_write(8'hA5);
    check("one_empty", 32'(empty), 32'd0);
    check("one_count", 32'(count), 32'd1);
    check("one_dout", 32'(dout), 32'hA5);
    do_pop();
    check("pop_empty", 32'(empty), 32'd1);
    check("pop_count", 32'(count), 32'd0);
    do_pop();
    check("rd_on_empty_count", 32'(count), 32'd0);
    check("rd_on_empty_empty", 32'(empty), 32'd1);

    // Fill to 16; almost_full from count 12.
    for (int i = 0; i < 16; i++) begin
      do_write(8'(i));
      check($sformatf("fill_af_%0d", i + 1), 32'(almost_full), (i + 1 >= 12) ? 32'd1 : 32'd0);
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    check("fill_head", 32'(dout), 32'h00);

    // Dropped write sets overflow; clear; clear coincident with drop keeps it set.
    do_write(8'h55);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_head", 32'(dout), 32'h00);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
    clr_ovf = 1'b1;
    do_write(8'h56);
    clr_ovf = 1'b0;
    check("ovf_set_wins", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_clr2", 32'(overflow), 32'd0);

    // Write and pop together while full: oldest leaves, 77 joins at the tail.
    wr  = 1'b1;
    rd  = 1'b1;
    din = 8'h77;
    tick();
    wr  = 1'b0;
    rd  = 1'b0;
    check("wrrd_full_count", 32'(count), 32'd16);
    check("wrrd_full_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("drain_%0d", i), 32'(dout), 32'(i));
      do_pop();
    end
    check("drain_last", 32'(dout), 32'h77);
    do_pop();
    check("drain_empty", 32'(empty), 32'd1);

    // Simultaneous write and pop when empty: only the write lands.
    wr  = 1'b1;
    rd  = 1'b1;
    din = 8'h9E;
    tick();
    wr  = 1'b0;
    rd  = 1'b0;
    check("wrrd_empty_count", 32'(count), 32'd1);
    check("wrrd_empty_dout", 32'(dout), 32'h9E);
    do_pop();

    // Character timeout.
    do_write(8'h11);
    for (int i = 0; i < 639; i++) begin
      s_tick = 1'b1;
      tick();
      s_tick = 1'b0;
    end
    check("to_639", 32'(timeout), 32'd0);
    s_tick = 1'b1;
    tick();
    s_tick = 1'b0;
`ifdef UART_RX_FIFO_TIMEOUT_EN
    check("to_640", 32'(timeout), 32'd1);
`else
    check("to_640", 32'(timeout), 32'd0);
`endif
    do_pop();
    check("to_cleared", 32'(timeout), 32'd0);
    check("to_empty", 32'(empty), 32'd1);

    // Reset mid-burst: asynchronous return to reset values.
    wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 8'hC0 + 8'(i);
      tick();
    end
    check("burst_count", 32'(count), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    wr = 1'b0;
    check_reset_state("midrst");
    tick();
    reset_n = 1'b1;
    tick();
    do_write(8'h3C);
    check("post_rst_dout", 32'(dout), 32'h3C);
    check("post_rst_count", 32'(count), 32'd1);
    do_pop();
    check("post_rst_empty", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
